// File: rtl/fetch_buffer.sv
// fetch_buffer: N_WAY-wide circular instruction queue between fetch and decode.
// Fetch pushes up to N_WAY {PC,inst} pairs per cycle (valid lanes compacted),
// dispatch pops 0..N_WAY oldest entries per cycle. The head N_WAY entries drive
// the decoder. flush clears the queue on a branch mispredict.
// Optional: define FETCH_BUF_STATS_EN to add saturating stall/flush counters.
module fetch_buffer #(
  parameter int unsigned N_WAY = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 32,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1),
  localparam int unsigned DeqW = $clog2(N_WAY + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [N_WAY*XLEN-1:0] in_PC,
  input  logic [N_WAY*32-1:0]   in_inst,
  input  logic [N_WAY-1:0]      in_valid,
  output logic                  in_ready,
  input  logic [DeqW-1:0]       deq_count,
  output logic [N_WAY*XLEN-1:0] out_PC,
  output logic [N_WAY*32-1:0]   out_inst,
  output logic [N_WAY-1:0]      out_valid,
  output logic [CntW-1:0]       count
`ifdef FETCH_BUF_STATS_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
`endif
);

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic            enq_ok;
  logic [CntW-1:0] push_cnt;
  logic [CntW-1:0] push_eff;
  logic [CntW-1:0] deq_eff;
  logic [PtrW-1:0] lane_off [N_WAY];
  logic [PtrW-1:0] rd_idx;

  // Ready depends on the registered count only, never on deq_count.
  assign in_ready = (count_q <= CntW'(DEPTH - N_WAY));
  assign count    = count_q;
  assign enq_ok   = in_ready && !flush;

  // Lane write offsets (compaction), clamped dequeue amount and next pointers.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < N_WAY; i++) begin
      lane_off[i] = push_cnt[PtrW-1:0];
      push_cnt    = push_cnt + CntW'(in_valid[i]);
    end
    push_eff = enq_ok ? push_cnt : '0;

    deq_eff = CntW'(deq_count);
    if (deq_eff > count_q)         deq_eff = count_q;
    if (deq_eff > CntW'(N_WAY))    deq_eff = CntW'(N_WAY);

    head_d  = head_q + deq_eff[PtrW-1:0];
    tail_d  = tail_q + push_eff[PtrW-1:0];
    count_d = count_q + push_eff - deq_eff;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; not reset, validity is tracked by count.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_WAY; i++) begin
      if (enq_ok && in_valid[i]) begin
        pc_mem[tail_q + lane_off[i]]   <= in_PC[i*XLEN +: XLEN];
        inst_mem[tail_q + lane_off[i]] <= in_inst[i*32 +: 32];
      end
    end
  end

  // Head window to decoder; invalid lanes are forced to zero.
  always_comb begin
    out_PC    = '0;
    out_inst  = '0;
    out_valid = '0;
    rd_idx    = '0;
    for (int i = 0; i < N_WAY; i++) begin
      rd_idx       = head_q + PtrW'(i);
      out_valid[i] = (count_q > CntW'(i));
      if (out_valid[i]) begin
        out_PC[i*XLEN +: XLEN] = pc_mem[rd_idx];
        out_inst[i*32 +: 32]   = inst_mem[rd_idx];
      end
    end
  end

`ifdef FETCH_BUF_STATS_EN
  // Saturating counters: fetch back-pressure cycles and flush cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if ((|in_valid) && !in_ready && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (flush && (flush_count != '1)) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: table-driven vectors plus a FIFO scoreboard for fetch_buffer
// (N_WAY=2, DEPTH=8, XLEN=32). Hand sequences cover compaction, wrap, clamp,
// flush and asynchronous reset.
module tb_fetch_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic [63:0] in_PC;
  logic [63:0] in_inst;
  logic [1:0]  in_valid;
  logic        in_ready;
  logic [1:0]  deq_count;
  logic [63:0] out_PC;
  logic [63:0] out_inst;
  logic [1:0]  out_valid;
  logic [3:0]  count;
`ifdef FETCH_BUF_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  fetch_buffer #(
    .N_WAY(2),
    .DEPTH(8),
    .XLEN (32)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_PC    (in_PC),
    .in_inst  (in_inst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .deq_count(deq_count),
    .out_PC   (out_PC),
    .out_inst (out_inst),
    .out_valid(out_valid),
    .count    (count)
`ifdef FETCH_BUF_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
`endif
  );

  always #5 clock = ~clock;

  int tests  = 0;
  int failed = 0;

  // Scoreboard: {pc, inst} in expected dequeue order.
  logic [63:0] mq[$];

  typedef struct {
    logic [1:0]  v;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [1:0]  dq;
    logic        fl;
    int          exp_count;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Occupancy, ready and zeroed invalid lanes against the scoreboard depth.
  task automatic check_outputs();
    int n;
    n = mq.size();
    chk("count", 32'(count), 32'(n));
    chk("in_ready", 32'(in_ready), 32'(n <= 6));
    for (int i = 0; i < 2; i++) begin
      chk("out_valid", 32'(out_valid[i]), 32'(i < n));
      if (i >= n) begin
        chk("idle_pc_zero", out_PC[i*32 +: 32], 32'h0);
        chk("idle_inst_zero", out_inst[i*32 +: 32], 32'h0);
      end
    end
  endtask

  // One cycle: drive, check, update model (pop-compare then push), clock.
  task automatic step(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                      input logic [1:0] dq, input logic fl);
    int          n;
    int          eff;
    bit          rdy;
    logic [63:0] e;
    logic [31:0] p;
    in_valid  = v;
    in_PC     = {p1, p0};
    in_inst   = {mk_inst(p1), mk_inst(p0)};
    deq_count = dq;
    flush     = fl;
    #1;
    check_outputs();
    if (fl) begin
      mq.delete();
    end else begin
      n   = mq.size();
      rdy = (8 - n) >= 2;
      eff = int'(dq);
      if (eff > n) eff = n;
      if (eff > 2) eff = 2;
      for (int i = 0; i < eff; i++) begin
        e = mq.pop_front();
        chk("deq_pc", out_PC[i*32 +: 32], e[63:32]);
        chk("deq_inst", out_inst[i*32 +: 32], e[31:0]);
      end
      if (rdy) begin
        for (int i = 0; i < 2; i++) begin
          if (v[i]) begin
            p = (i == 0) ? p0 : p1;
            mq.push_back({p, mk_inst(p)});
          end
        end
      end
    end
    @(posedge clock);
    #1;
    in_valid  = '0;
    deq_count = '0;
    flush     = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{2'b11, 32'h00,  32'h04,  2'd0, 1'b0, 2, 1'b1};
    vecs[1]  = '{2'b11, 32'h08,  32'h0C,  2'd0, 1'b0, 4, 1'b1};
    vecs[2]  = '{2'b11, 32'h10,  32'h14,  2'd0, 1'b0, 6, 1'b1};
    vecs[3]  = '{2'b11, 32'h18,  32'h1C,  2'd0, 1'b0, 8, 1'b0};
    vecs[4]  = '{2'b11, 32'h20,  32'h24,  2'd0, 1'b0, 8, 1'b0};  // dropped while full
    vecs[5]  = '{2'b00, 32'h0,   32'h0,   2'd2, 1'b0, 6, 1'b1};
    vecs[6]  = '{2'b00, 32'h0,   32'h0,   2'd3, 1'b0, 4, 1'b1};  // clamped to N_WAY
    vecs[7]  = '{2'b10, 32'h0,   32'h50,  2'd0, 1'b0, 5, 1'b1};
    vecs[8]  = '{2'b01, 32'h54,  32'h0,   2'd1, 1'b0, 5, 1'b1};
    vecs[9]  = '{2'b11, 32'h60,  32'h64,  2'd2, 1'b1, 0, 1'b1};  // flush wins
    vecs[10] = '{2'b10, 32'h0,   32'h80,  2'd0, 1'b0, 1, 1'b1};
    vecs[11] = '{2'b00, 32'h0,   32'h0,   2'd3, 1'b0, 0, 1'b1};  // clamp to count
    vecs[12] = '{2'b00, 32'h0,   32'h0,   2'd2, 1'b0, 0, 1'b1};  // empty, ignored

    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = '0;
    in_PC     = '0;
    in_inst   = '0;
    deq_count = '0;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_PC[31:0], 32'h0);
    @(negedge clock);
    reset = 1'b1;
    #1;

    for (int k = 0; k < 13; k++) begin
      step(vecs[k].v, vecs[k].pc0, vecs[k].pc1, vecs[k].dq, vecs[k].fl);
      chk("tbl_count", 32'(count), 32'(vecs[k].exp_count));
      chk("tbl_ready", 32'(in_ready), 32'(vecs[k].exp_ready));
    end

    // Compaction: lone lane-1 entry lands in head lane 0.
    step(2'b10, 32'h0, 32'h40, 2'd0, 1'b0);
    chk("compact_pc", out_PC[31:0], 32'h40);
    chk("compact_valid", 32'(out_valid), 32'b01);
    step(2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    chk("clamp_count", 32'(count), 32'd0);

    // Steady push 2 / pop 2 across the pointer wrap.
    step(2'b11, 32'h100, 32'h104, 2'd0, 1'b0);
    step(2'b11, 32'h108, 32'h10C, 2'd0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(2'b11, 32'h110 + 32'(8 * k), 32'h114 + 32'(8 * k), 2'd2, 1'b0);
      chk("wrap_count", 32'(count), 32'd4);
    end

    // Flush at count 6 with same-cycle push and pop.
    step(2'b11, 32'h200, 32'h204, 2'd0, 1'b0);
    chk("pre_flush_count", 32'(count), 32'd6);
    step(2'b11, 32'h208, 32'h20C, 2'd2, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-traffic.
    step(2'b11, 32'h280, 32'h284, 2'd0, 1'b0);
    in_valid = 2'b11;
    in_PC    = {32'h28C, 32'h288};
    in_inst  = {mk_inst(32'h28C), mk_inst(32'h288)};
    #2;
    reset = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    mq.delete();
    in_valid = '0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    step(2'b11, 32'h300, 32'h304, 2'd0, 1'b0);
    chk("post_rst_count", 32'(count), 32'd2);
    step(2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    chk("post_rst_drain", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
